// File: rtl/morse_key_encoder.sv
// Morse key encoder: accepts one ASCII character per handshake and plays it
// as timed key-down (mark) / key-up (gap) intervals on key_out.
module morse_key_encoder #(
    parameter int UNIT_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       key_out,
    output logic       sym_dash,
    output logic       busy,
    output logic       char_done,
    output logic       bad_char
);

    // Timer must hold the longest interval (word gap, 7 units) minus one.
    localparam int TW = $clog2(7 * UNIT_CYCLES + 1);

    localparam logic [TW-1:0] DOT_LOAD  = TW'(UNIT_CYCLES - 1);
    localparam logic [TW-1:0] DASH_LOAD = TW'(3 * UNIT_CYCLES - 1);
    localparam logic [TW-1:0] LGAP_LOAD = TW'(3 * UNIT_CYCLES - 1);
    localparam logic [TW-1:0] WGAP_LOAD = TW'(7 * UNIT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MARK = 3'd1,
        ST_SGAP = 3'd2,
        ST_LGAP = 3'd3,
        ST_WGAP = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [4:0]     shreg_q, shreg_d;    // bit 4 is the symbol being (or about to be) sent
    logic [2:0]     remain_q, remain_d;  // symbols still to send after the current one

    logic           char_ready_q, char_ready_d;
    logic           key_out_q, key_out_d;
    logic           sym_dash_q, sym_dash_d;
    logic           busy_q, busy_d;
    logic           char_done_q, char_done_d;
    logic           bad_char_q, bad_char_d;

    logic [7:0]     ch_upper;
    logic [2:0]     code_len;
    logic [4:0]     code_pat;     // right-aligned, 1 = dash
    logic [4:0]     code_aligned; // left-aligned so the first symbol sits in bit 4
    logic           is_space;
    logic           is_supported;

    // Code ROM: fold lowercase onto uppercase, then look up length and pattern.
    always_comb begin
        ch_upper = char_in;
        if (char_in >= 8'h61 && char_in <= 8'h7A) begin
            ch_upper = char_in - 8'h20;
        end
        code_len = 3'd0;
        code_pat = 5'b00000;
        case (ch_upper)
            8'h41: {code_len, code_pat} = {3'd2, 5'b00001}; // A .-
            8'h42: {code_len, code_pat} = {3'd4, 5'b01000}; // B -...
            8'h43: {code_len, code_pat} = {3'd4, 5'b01010}; // C -.-.
            8'h44: {code_len, code_pat} = {3'd3, 5'b00100}; // D -..
            8'h45: {code_len, code_pat} = {3'd1, 5'b00000}; // E .
            8'h46: {code_len, code_pat} = {3'd4, 5'b00010}; // F ..-.
            8'h47: {code_len, code_pat} = {3'd3, 5'b00110}; // G --.
            8'h48: {code_len, code_pat} = {3'd4, 5'b00000}; // H ....
            8'h49: {code_len, code_pat} = {3'd2, 5'b00000}; // I ..
            8'h4A: {code_len, code_pat} = {3'd4, 5'b00111}; // J .---
            8'h4B: {code_len, code_pat} = {3'd3, 5'b00101}; // K -.-
            8'h4C: {code_len, code_pat} = {3'd4, 5'b00100}; // L .-..
            8'h4D: {code_len, code_pat} = {3'd2, 5'b00011}; // M --
            8'h4E: {code_len, code_pat} = {3'd2, 5'b00010}; // N -.
            8'h4F: {code_len, code_pat} = {3'd3, 5'b00111}; // O ---
            8'h50: {code_len, code_pat} = {3'd4, 5'b00110}; // P .--.
            8'h51: {code_len, code_pat} = {3'd4, 5'b01101}; // Q --.-
            8'h52: {code_len, code_pat} = {3'd3, 5'b00010}; // R .-.
            8'h53: {code_len, code_pat} = {3'd3, 5'b00000}; // S ...
            8'h54: {code_len, code_pat} = {3'd1, 5'b00001}; // T -
            8'h55: {code_len, code_pat} = {3'd3, 5'b00001}; // U ..-
            8'h56: {code_len, code_pat} = {3'd4, 5'b00001}; // V ...-
            8'h57: {code_len, code_pat} = {3'd3, 5'b00011}; // W .--
            8'h58: {code_len, code_pat} = {3'd4, 5'b01001}; // X -..-
            8'h59: {code_len, code_pat} = {3'd4, 5'b01011}; // Y -.--
            8'h5A: {code_len, code_pat} = {3'd4, 5'b01100}; // Z --..
            8'h30: {code_len, code_pat} = {3'd5, 5'b11111}; // 0
            8'h31: {code_len, code_pat} = {3'd5, 5'b01111}; // 1
            8'h32: {code_len, code_pat} = {3'd5, 5'b00111}; // 2
            8'h33: {code_len, code_pat} = {3'd5, 5'b00011}; // 3
            8'h34: {code_len, code_pat} = {3'd5, 5'b00001}; // 4
            8'h35: {code_len, code_pat} = {3'd5, 5'b00000}; // 5
            8'h36: {code_len, code_pat} = {3'd5, 5'b10000}; // 6
            8'h37: {code_len, code_pat} = {3'd5, 5'b11000}; // 7
            8'h38: {code_len, code_pat} = {3'd5, 5'b11100}; // 8
            8'h39: {code_len, code_pat} = {3'd5, 5'b11110}; // 9
            default: {code_len, code_pat} = {3'd0, 5'b00000};
        endcase
        code_aligned = code_pat << (3'd5 - code_len);
        is_space     = (char_in == 8'h20);
        is_supported = (code_len != 3'd0);
    end

    // Next-state, timer, symbol shifter and next-cycle output values.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        shreg_d  = shreg_q;
        remain_d = remain_q;

        case (state_q)
            ST_IDLE: begin
                if (char_valid) begin
                    if (is_space) begin
                        state_d = ST_WGAP;
                        timer_d = WGAP_LOAD;
                    end else if (is_supported) begin
                        state_d  = ST_MARK;
                        shreg_d  = code_aligned;
                        remain_d = code_len - 3'd1;
                        timer_d  = code_aligned[4] ? DASH_LOAD : DOT_LOAD;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_MARK: begin
                if (timer_q == '0) begin
                    if (remain_q != 3'd0) begin
                        state_d  = ST_SGAP;
                        timer_d  = DOT_LOAD;
                        shreg_d  = {shreg_q[3:0], 1'b0};
                        remain_d = remain_q - 3'd1;
                    end else begin
                        state_d = ST_LGAP;
                        timer_d = LGAP_LOAD;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_SGAP: begin
                if (timer_q == '0) begin
                    state_d = ST_MARK;
                    timer_d = shreg_q[4] ? DASH_LOAD : DOT_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_LGAP, ST_WGAP: begin
                if (timer_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are computed from the next state so they are flops, not decodes.
        char_ready_d = (state_d == ST_IDLE);
        key_out_d    = (state_d == ST_MARK);
        sym_dash_d   = (state_d == ST_MARK) && shreg_d[4];
        busy_d       = (state_d == ST_MARK) || (state_d == ST_SGAP) ||
                       (state_d == ST_LGAP) || (state_d == ST_WGAP);
        char_done_d  = ((state_d == ST_LGAP) || (state_d == ST_WGAP)) && (timer_d == '0);
        bad_char_d   = (state_d == ST_ERR);
    end

    // State, timer and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            shreg_q      <= '0;
            remain_q     <= '0;
            char_ready_q <= 1'b1;
            key_out_q    <= 1'b0;
            sym_dash_q   <= 1'b0;
            busy_q       <= 1'b0;
            char_done_q  <= 1'b0;
            bad_char_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            shreg_q      <= shreg_d;
            remain_q     <= remain_d;
            char_ready_q <= char_ready_d;
            key_out_q    <= key_out_d;
            sym_dash_q   <= sym_dash_d;
            busy_q       <= busy_d;
            char_done_q  <= char_done_d;
            bad_char_q   <= bad_char_d;
        end
    end

    assign char_ready = char_ready_q;
    assign key_out    = key_out_q;
    assign sym_dash   = sym_dash_q;
    assign busy       = busy_q;
    assign char_done  = char_done_q;
    assign bad_char   = bad_char_q;

endmodule

// File: tb/tb_morse_key_encoder.sv
// Self-checking bench for morse_key_encoder with UNIT_CYCLES=4.
module tb_morse_key_encoder;

    localparam int U = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready, key_out, sym_dash, busy, char_done, bad_char;

    int total = 0;
    int bad   = 0;
    int accept_cnt = 0;

    always #5 clk = ~clk;

    morse_key_encoder #(.UNIT_CYCLES(U)) dut (
        .clk        (clk),
        .reset      (reset),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .key_out    (key_out),
        .sym_dash   (sym_dash),
        .busy       (busy),
        .char_done  (char_done),
        .bad_char   (bad_char)
    );

    // Count handshakes seen by the design (measurement only).
    always @(posedge clk) begin
        if (!reset && char_valid && char_ready) accept_cnt <= accept_cnt + 1;
    end

    // Expected per-cycle output record: {key, dash, busy, done, bad, ready}.
    typedef struct packed {
        logic key;
        logic dash;
        logic busy;
        logic done;
        logic bad;
        logic ready;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        logic [7:0] ch;
        int done_cyc;
        int busy_cnt;
        int high_cnt;
        int last_high;
        int bad_cyc;
        int ready_cyc;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Reference: Morse text of a character as a dot/dash string ("" = unsupported).
    function automatic string morse_of(input logic [7:0] c);
        logic [7:0] u;
        u = c;
        if (u >= 8'h61 && u <= 8'h7A) u = u - 8'd32;
        case (u)
            "A": return ".-";    "B": return "-...";  "C": return "-.-.";
            "D": return "-..";   "E": return ".";     "F": return "..-.";
            "G": return "--.";   "H": return "....";  "I": return "..";
            "J": return ".---";  "K": return "-.-";   "L": return ".-..";
            "M": return "--";    "N": return "-.";    "O": return "---";
            "P": return ".--.";  "Q": return "--.-";  "R": return ".-.";
            "S": return "...";   "T": return "-";     "U": return "..-";
            "V": return "...-";  "W": return ".--";   "X": return "-..-";
            "Y": return "-.--";  "Z": return "--..";
            "0": return "-----"; "1": return ".----"; "2": return "..---";
            "3": return "...--"; "4": return "....-"; "5": return ".....";
            "6": return "-...."; "7": return "--..."; "8": return "---..";
            "9": return "----.";
            default: return "";
        endcase
    endfunction

    function automatic void push_run(input int n, input logic key, input logic dash, input logic done_last);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{key: key, dash: dash, busy: 1'b1,
                              done: (done_last && i == n - 1), bad: 1'b0, ready: 1'b0});
        end
    endfunction

    // Append the cycles following acceptance of c, ending with one idle cycle.
    function automatic void append_exp(input logic [7:0] c);
        string m;
        m = morse_of(c);
        if (c == 8'h20) begin
            push_run(7 * U, 1'b0, 1'b0, 1'b1);
        end else if (m.len() == 0) begin
            exp_q.push_back('{key: 1'b0, dash: 1'b0, busy: 1'b0, done: 1'b0, bad: 1'b1, ready: 1'b0});
        end else begin
            for (int i = 0; i < m.len(); i++) begin
                logic d;
                d = (m[i] == "-");
                push_run((d ? 3 : 1) * U, 1'b1, d, 1'b0);
                if (i < m.len() - 1) push_run(U, 1'b0, 1'b0, 1'b0);
            end
            push_run(3 * U, 1'b0, 1'b0, 1'b1);
        end
        exp_q.push_back('{key: 1'b0, dash: 1'b0, busy: 1'b0, done: 1'b0, bad: 1'b0, ready: 1'b1});
    endfunction

    function automatic logic [7:0] rand_char();
        case ($urandom_range(0, 4))
            0: return 8'h41 + 8'($urandom_range(0, 25));
            1: return 8'h61 + 8'($urandom_range(0, 25));
            2: return 8'h30 + 8'($urandom_range(0, 9));
            3: return 8'h20;
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic exp_t dut_out();
        return '{key: key_out, dash: sym_dash, busy: busy, done: char_done, bad: bad_char, ready: char_ready};
    endfunction

    // Play one character from a negedge in IDLE, checking every cycle against the model.
    // While busy, char_valid/char_in are jittered to show they are ignored.
    task automatic play(input logic [7:0] c, input string tag);
        int bad0;
        bad0 = bad;
        check({tag, "_ready_pre"}, 32'(char_ready), 32'd1);
        char_in    = c;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        char_in    = 8'($urandom);
        exp_q.delete();
        append_exp(c);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check($sformatf("%s_cyc%0d", tag, i + 1), 32'(dut_out()), 32'(exp_q[i]));
            char_in    = 8'($urandom);
            char_valid = exp_q[i].ready ? 1'b0 : 1'($urandom);
        end
        char_valid = 1'b0;
        $display("char 0x%02h '%c' %0d cycles, errors %0d", c, c, exp_q.size(), bad - bad0);
    endtask

    // Measure summary timing figures of one character (starting at a negedge in IDLE).
    task automatic measure(input vec_t v, input int idx);
        int done_cyc, busy_cnt, high_cnt, last_high, bad_cyc, ready_cyc;
        string t;
        done_cyc = 0; busy_cnt = 0; high_cnt = 0; last_high = 0; bad_cyc = 0; ready_cyc = 0;
        t = $sformatf("vec%0d", idx);
        char_in    = v.ch;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        for (int cyc = 1; cyc <= 150; cyc++) begin
            @(negedge clk);
            if (key_out) begin high_cnt++; last_high = cyc; end
            if (busy) busy_cnt++;
            if (char_done && done_cyc == 0) done_cyc = cyc;
            if (bad_char && bad_cyc == 0) bad_cyc = cyc;
            if (char_ready) begin ready_cyc = cyc; break; end
        end
        check({t, "_done_cyc"},  32'(done_cyc),  32'(v.done_cyc));
        check({t, "_busy_cnt"},  32'(busy_cnt),  32'(v.busy_cnt));
        check({t, "_high_cnt"},  32'(high_cnt),  32'(v.high_cnt));
        check({t, "_last_high"}, 32'(last_high), 32'(v.last_high));
        check({t, "_bad_cyc"},   32'(bad_cyc),   32'(v.bad_cyc));
        check({t, "_ready_cyc"}, 32'(ready_cyc), 32'(v.ready_cyc));
        $display("vector %0d char 0x%02h done@%0d high=%0d ready@%0d", idx, v.ch, done_cyc, high_cnt, ready_cyc);
    endtask

    initial begin
        vec_t vecs[5];
        exp_t idle_exp;
        logic [7:0] sos[3];
        int acc0, k, done_seen;

        vecs[0] = '{8'h41, 32, 32, 16, 20, 0, 33};  // 'A'
        vecs[1] = '{8'h65, 16, 16,  4,  4, 0, 17};  // 'e'
        vecs[2] = '{8'h30, 88, 88, 60, 76, 0, 89};  // '0'
        vecs[3] = '{8'h20, 28, 28,  0,  0, 0, 29};  // space
        vecs[4] = '{8'h23,  0,  0,  0,  0, 1,  2};  // '#'
        idle_exp = '{key: 1'b0, dash: 1'b0, busy: 1'b0, done: 1'b0, bad: 1'b0, ready: 1'b1};

        // Reset state.
        reset = 1'b1; char_valid = 1'b1; char_in = 8'h41;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'(dut_out()), 32'(idle_exp));
        char_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("idle_outputs", 32'(dut_out()), 32'(idle_exp));

        // Table-driven spec vectors.
        for (int i = 0; i < 5; i++) measure(vecs[i], i);

        // "SOS" with char_valid held high across all three characters.
        sos[0] = "S"; sos[1] = "O"; sos[2] = "S";
        exp_q.delete();
        for (int i = 0; i < 3; i++) append_exp(sos[i]);
        acc0 = accept_cnt;
        k = 1;
        char_in = sos[0];
        char_valid = 1'b1;
        @(posedge clk);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check($sformatf("sos_cyc%0d", i + 1), 32'(dut_out()), 32'(exp_q[i]));
            if (exp_q[i].ready) begin
                if (k < 3) begin char_in = sos[k]; k++; end
                else char_valid = 1'b0;
            end
        end
        char_valid = 1'b0;
        @(negedge clk);
        check("sos_accepts", 32'(accept_cnt - acc0), 32'd3);
        $display("sequence SOS streamed, %0d acceptances", accept_cnt - acc0);

        // Reset in the middle of 'O', then 'T' plays normally.
        char_in = "O"; char_valid = 1'b1;
        @(posedge clk);
        #1 char_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_mid_key_c10", 32'(key_out), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_c11", 32'(dut_out()), 32'(idle_exp));
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (char_done || bad_char || key_out || !char_ready) done_seen++;
        end
        check("rst_mid_quiet", 32'(done_seen), 32'd0);
        $display("reset mid-character 'O' recovered");
        play("T", "after_rst_T");

        // Directed corner characters through the full per-cycle model.
        play("A", "dir_A");
        play("e", "dir_e");
        play("0", "dir_0");
        play(8'h20, "dir_space");
        play("#", "dir_hash");

        // Randomized characters against the reference model.
        for (int i = 0; i < 40; i++) begin
            play(rand_char(), $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
